// File: rtl/jtag_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_sequencer
// Brief    : IEEE 1149.1 TAP controller with a registered TDO-source
//            scheduler. Decodes the 16-state TAP into the IR/DR strobes and,
//            at each Capture, latches which data register owns TDO for the
//            following shift.
// Options  : JTAG_IDCODE_DEFAULT_EN - while in Test-Logic-Reset the effective
//            instruction is forced to IDCODE until the first Update-IR.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_sequencer #(
    parameter int                     IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS = 4'hF,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE = 4'h1,
    parameter logic [IR_WIDTH-1:0]    OP_SAMPLE = 4'h2,
    parameter logic [IR_WIDTH-1:0]    OP_EXTEST = 4'h0,
    parameter logic [IR_WIDTH-1:0]    OP_AHB    = 4'h8,
    parameter logic [IR_WIDTH-1:0]    OP_AHB_RD = 4'h9
) (
    input  logic                TCK,
    input  logic                rst,
    input  logic                TMS,
    input  logic [IR_WIDTH-1:0] instruction,
    input  logic                ahb_error,
    output logic [3:0]          tap_state,
    output logic                tlr_reset,
    output logic                capture_ir,
    output logic                ir_shift,
    output logic                update_ir,
    output logic                capture_dr,
    output logic                dr_shift,
    output logic                update_dr,
    output logic [2:0]          tdo_sel,
    output logic                tdo_en,
    output logic                ahb,
    output logic                ahb_read,
    output logic                idcode,
    output logic                tmp_status
);

    // TAP state encoding (standard 1149.1 values)
    localparam logic [3:0] c_TLR      = 4'hF;
    localparam logic [3:0] c_RTI      = 4'hC;
    localparam logic [3:0] c_SEL_DR   = 4'h7;
    localparam logic [3:0] c_CAP_DR   = 4'h6;
    localparam logic [3:0] c_SH_DR    = 4'h2;
    localparam logic [3:0] c_EX1_DR   = 4'h1;
    localparam logic [3:0] c_PAUSE_DR = 4'h3;
    localparam logic [3:0] c_EX2_DR   = 4'h0;
    localparam logic [3:0] c_UPD_DR   = 4'h5;
    localparam logic [3:0] c_SEL_IR   = 4'h4;
    localparam logic [3:0] c_CAP_IR   = 4'hE;
    localparam logic [3:0] c_SH_IR    = 4'hA;
    localparam logic [3:0] c_EX1_IR   = 4'h9;
    localparam logic [3:0] c_PAUSE_IR = 4'hB;
    localparam logic [3:0] c_EX2_IR   = 4'h8;
    localparam logic [3:0] c_UPD_IR   = 4'hD;

    // TDO source select codes
    localparam logic [2:0] c_SEL_NONE   = 3'd0;
    localparam logic [2:0] c_SEL_INSTR  = 3'd1;
    localparam logic [2:0] c_SEL_BYPASS = 3'd2;
    localparam logic [2:0] c_SEL_BSR    = 3'd3;
    localparam logic [2:0] c_SEL_IDCODE = 3'd4;
    localparam logic [2:0] c_SEL_AHB    = 3'd5;
    localparam logic [2:0] c_SEL_STATUS = 3'd6;

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic [2:0]          r_tdo_sel;
    logic                r_tdo_en;
    logic                r_rd_latched;
    logic [IR_WIDTH-1:0] w_eff_instr;
    logic [2:0]          w_dr_sel;

`ifdef JTAG_IDCODE_DEFAULT_EN
    logic r_idcode_force;

    // Override is armed whenever the TAP sits in (or returns to) TLR and is
    // dropped on the first Update-IR, when a real instruction takes effect.
    always_ff @(posedge TCK) begin
        if (rst || w_state_nxt == c_TLR) begin
            r_idcode_force <= 1'b1;
        end else if (w_state_nxt == c_UPD_IR) begin
            r_idcode_force <= 1'b0;
        end
    end

    assign w_eff_instr = r_idcode_force ? OP_IDCODE : instruction;
`else
    assign w_eff_instr = instruction;
`endif

    // TAP state register; reset wins over TMS in every state
    always_ff @(posedge TCK) begin
        if (rst) begin
            r_state <= c_TLR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // 1149.1 next-state table
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_TLR:      w_state_nxt = TMS ? c_TLR    : c_RTI;
            c_RTI:      w_state_nxt = TMS ? c_SEL_DR : c_RTI;
            c_SEL_DR:   w_state_nxt = TMS ? c_SEL_IR : c_CAP_DR;
            c_CAP_DR:   w_state_nxt = TMS ? c_EX1_DR : c_SH_DR;
            c_SH_DR:    w_state_nxt = TMS ? c_EX1_DR : c_SH_DR;
            c_EX1_DR:   w_state_nxt = TMS ? c_UPD_DR : c_PAUSE_DR;
            c_PAUSE_DR: w_state_nxt = TMS ? c_EX2_DR : c_PAUSE_DR;
            c_EX2_DR:   w_state_nxt = TMS ? c_UPD_DR : c_SH_DR;
            c_UPD_DR:   w_state_nxt = TMS ? c_SEL_DR : c_RTI;
            c_SEL_IR:   w_state_nxt = TMS ? c_TLR    : c_CAP_IR;
            c_CAP_IR:   w_state_nxt = TMS ? c_EX1_IR : c_SH_IR;
            c_SH_IR:    w_state_nxt = TMS ? c_EX1_IR : c_SH_IR;
            c_EX1_IR:   w_state_nxt = TMS ? c_UPD_IR : c_PAUSE_IR;
            c_PAUSE_IR: w_state_nxt = TMS ? c_EX2_IR : c_PAUSE_IR;
            c_EX2_IR:   w_state_nxt = TMS ? c_UPD_IR : c_SH_IR;
            c_UPD_IR:   w_state_nxt = TMS ? c_SEL_DR : c_RTI;
            default:    w_state_nxt = c_TLR;
        endcase
    end

    // DR-side TDO source chosen from the effective instruction at Capture-DR
    always_comb begin
        w_dr_sel = c_SEL_BYPASS;
        case (w_eff_instr)
            OP_IDCODE: w_dr_sel = c_SEL_IDCODE;
            OP_SAMPLE: w_dr_sel = c_SEL_BSR;
            OP_EXTEST: w_dr_sel = c_SEL_BSR;
            OP_AHB:    w_dr_sel = ahb_error ? c_SEL_STATUS : c_SEL_AHB;
            OP_AHB_RD: w_dr_sel = ahb_error ? c_SEL_STATUS : c_SEL_AHB;
            OP_BYPASS: w_dr_sel = c_SEL_BYPASS;
            default:   w_dr_sel = c_SEL_BYPASS;
        endcase
    end

    // TDO select latched on leaving a Capture state and held through the
    // whole shift/pause loop; cleared on entry to TLR or Update-IR
    always_ff @(posedge TCK) begin
        if (rst) begin
            r_tdo_sel    <= c_SEL_NONE;
            r_rd_latched <= 1'b0;
        end else if (r_state == c_CAP_IR) begin
            r_tdo_sel <= c_SEL_INSTR;
        end else if (r_state == c_CAP_DR) begin
            r_tdo_sel    <= w_dr_sel;
            r_rd_latched <= (w_eff_instr == OP_AHB_RD);
        end else if (w_state_nxt == c_TLR || w_state_nxt == c_UPD_IR) begin
            r_tdo_sel <= c_SEL_NONE;
        end
    end

    // TDO driven one TCK behind the Shift state (previous state was Shift)
    always_ff @(posedge TCK) begin
        if (rst) begin
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= (r_state == c_SH_DR) || (r_state == c_SH_IR);
        end
    end

    assign tap_state  = r_state;
    assign tlr_reset  = (r_state == c_TLR);
    assign capture_ir = (r_state == c_CAP_IR);
    assign ir_shift   = (r_state == c_SH_IR);
    assign update_ir  = (r_state == c_UPD_IR);
    assign capture_dr = (r_state == c_CAP_DR);
    assign dr_shift   = (r_state == c_SH_DR);
    assign update_dr  = (r_state == c_UPD_DR);

    assign tdo_sel    = r_tdo_sel;
    assign tdo_en     = r_tdo_en;
    assign ahb        = (r_tdo_sel == c_SEL_AHB);
    assign idcode     = (r_tdo_sel == c_SEL_IDCODE);
    assign tmp_status = (r_tdo_sel == c_SEL_STATUS);
    assign ahb_read   = ahb & r_rd_latched;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_sequencer
// Brief    : Directed self-checking bench for jtag_tap_sequencer. Expected
//            values are hand-derived from the 1149.1 state table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_sequencer;

    logic       TCK = 1'b0;
    logic       rst = 1'b1;
    logic       TMS = 1'b1;
    logic [3:0] instruction = 4'h1;
    logic       ahb_error = 1'b0;
    logic [3:0] tap_state;
    logic       tlr_reset, capture_ir, ir_shift, update_ir;
    logic       capture_dr, dr_shift, update_dr;
    logic [2:0] tdo_sel;
    logic       tdo_en, ahb, ahb_read, idcode, tmp_status;

    int n_checks = 0;
    int n_fails  = 0;

    jtag_tap_sequencer u_dut (
        .TCK         (TCK),
        .rst         (rst),
        .TMS         (TMS),
        .instruction (instruction),
        .ahb_error   (ahb_error),
        .tap_state   (tap_state),
        .tlr_reset   (tlr_reset),
        .capture_ir  (capture_ir),
        .ir_shift    (ir_shift),
        .update_ir   (update_ir),
        .capture_dr  (capture_dr),
        .dr_shift    (dr_shift),
        .update_dr   (update_dr),
        .tdo_sel     (tdo_sel),
        .tdo_en      (tdo_en),
        .ahb         (ahb),
        .ahb_read    (ahb_read),
        .idcode      (idcode),
        .tmp_status  (tmp_status)
    );

    // 100 MHz-style free-running TCK
    always #5 TCK = ~TCK;

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        n_fails = n_fails + 1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply TMS, clock once, then settle 1 time unit past the edge
    task automatic step(input logic tms);
        TMS = tms;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        // Reset with TMS high (rst wins)
        @(posedge TCK);
        #1;
        rst = 1'b0;
        check("rst_state", {4'h0, tap_state}, 8'h0F);
        check("rst_tlr",   {7'h0, tlr_reset}, 8'h01);
        check("rst_sel",   {5'h0, tdo_sel},   8'h00);
        check("rst_en",    {7'h0, tdo_en},    8'h00);
        check("rst_capdr", {7'h0, capture_dr}, 8'h00);
        step(1'b0);
        check("rti", {4'h0, tap_state}, 8'h0C);

        // IDCODE DR scan
        step(1'b1);
        check("seldr", {4'h0, tap_state}, 8'h07);
        step(1'b0);
        check("capdr",     {4'h0, tap_state}, 8'h06);
        check("capdr_stb", {7'h0, capture_dr}, 8'h01);
        step(1'b0);
        check("shdr",       {4'h0, tap_state}, 8'h02);
        check("shdr_stb",   {7'h0, dr_shift},  8'h01);
        check("id_sel",     {5'h0, tdo_sel},   8'h04);
        check("id_onehot",  {7'h0, idcode},    8'h01);
        check("shdr_en0",   {7'h0, tdo_en},    8'h00);
        step(1'b0);
        check("shdr_en1",   {7'h0, tdo_en},    8'h01);

        // Five TMS=1 back to TLR: 1,5,7,4,F
        step(1'b1);
        check("ex1dr", {4'h0, tap_state}, 8'h01);
        step(1'b1);
        check("upddr",     {4'h0, tap_state}, 8'h05);
        check("upddr_stb", {7'h0, update_dr}, 8'h01);
        step(1'b1);
        check("seldr2", {4'h0, tap_state}, 8'h07);
        step(1'b1);
        check("selir",     {4'h0, tap_state}, 8'h04);
        check("selir_sel", {5'h0, tdo_sel},   8'h04);
        step(1'b1);
        check("tlr",     {4'h0, tap_state}, 8'h0F);
        check("tlr_stb", {7'h0, tlr_reset}, 8'h01);
        check("tlr_sel", {5'h0, tdo_sel},   8'h00);

        // IR scan with pause
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("capir",     {4'h0, tap_state}, 8'h0E);
        check("capir_stb", {7'h0, capture_ir}, 8'h01);
        step(1'b0);
        check("shir",     {4'h0, tap_state}, 8'h0A);
        check("shir_stb", {7'h0, ir_shift},  8'h01);
        check("ir_sel",   {5'h0, tdo_sel},   8'h01);
        check("shir_en0", {7'h0, tdo_en},    8'h00);
        step(1'b0);
        check("shir_en1", {7'h0, tdo_en},    8'h01);
        step(1'b1);
        step(1'b0);
        check("pauseir",     {4'h0, tap_state}, 8'h0B);
        check("pauseir_en",  {7'h0, tdo_en},    8'h00);
        check("pauseir_sel", {5'h0, tdo_sel},   8'h01);
        step(1'b1);
        step(1'b1);
        check("updir",     {4'h0, tap_state}, 8'h0D);
        check("updir_stb", {7'h0, update_ir}, 8'h01);
        check("updir_sel", {5'h0, tdo_sel},   8'h00);

        // AHB read with error -> status
        step(1'b0);
        instruction = 4'h9;
        ahb_error   = 1'b1;
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("err_sel",    {5'h0, tdo_sel},    8'h06);
        check("err_status", {7'h0, tmp_status}, 8'h01);
        check("err_ahb",    {7'h0, ahb},        8'h00);

        // AHB read without error
        step(1'b1);
        step(1'b1);
        step(1'b1);
        ahb_error = 1'b0;
        step(1'b0);
        step(1'b0);
        check("rd_sel",  {5'h0, tdo_sel},  8'h05);
        check("rd_ahb",  {7'h0, ahb},      8'h01);
        check("rd_read", {7'h0, ahb_read}, 8'h01);
        instruction = 4'hF;
        step(1'b0);
        check("midshift_sel", {5'h0, tdo_sel}, 8'h05);
        check("midshift_en",  {7'h0, tdo_en},  8'h01);

        // TMS=1 in CapDR: select latched, no shift
        step(1'b1);
        step(1'b1);
        step(1'b1);
        instruction = 4'h2;
        step(1'b0);
        step(1'b1);
        check("cap_ex1_state", {4'h0, tap_state}, 8'h01);
        check("cap_ex1_sel",   {5'h0, tdo_sel},   8'h03);
        check("cap_ex1_en",    {7'h0, tdo_en},    8'h00);

        // Re-enter ShDR via Pause/Exit2, then reset mid-shift
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("reshift_en", {7'h0, tdo_en}, 8'h01);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        check("midrst_state", {4'h0, tap_state}, 8'h0F);
        check("midrst_en",    {7'h0, tdo_en},    8'h00);
        check("midrst_sel",   {5'h0, tdo_sel},   8'h00);

        // Post-reset DR scan with SAMPLE on the instruction input
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
`ifdef JTAG_IDCODE_DEFAULT_EN
        check("default_id_sel", {5'h0, tdo_sel}, 8'h04);
`else
        check("default_id_sel", {5'h0, tdo_sel}, 8'h03);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
